// File: rtl/stepdown_softstart_seq.sv
// stepdown_softstart_seq: soft-start sequencer for the step-down converter.
// After enable it waits BLANK_CYC settle cycles and then ramps the reference DAC
// code from 0 to full scale, one step every (div_q+1) cycles. On fault or
// disable it discharges the code back to 0, one step per cycle.
// Ports:
//   CELCLK / CELRSTN  clock (rising edge) and asynchronous active-low reset
//   CELV / CELG / SUB supply, ground and substrate pins (no logic function)
//   en, fault         synchronous enable and level fault (fault wins)
//   div               cycles-per-step minus one, captured on BLANK->RAMP
//   ramp_code         reference DAC code
//   ss_busy           high in BLANK/RAMP/DISCHARGE (drives the 5V inverter input)
//   ss_done           high only in DONE
//   ss_state          IDLE=0 BLANK=1 RAMP=2 DONE=3 DISCHARGE=4
module stepdown_softstart_seq #(
   parameter int CODE_W    = 8,
   parameter int DIV_W     = 12,
   parameter int BLANK_CYC = 16
) (
   input  logic              CELCLK,
   input  logic              CELRSTN,
   input  logic              CELV,
   input  logic              CELG,
   input  logic              SUB,
   input  logic              en,
   input  logic              fault,
   input  logic [DIV_W-1:0]  div,
   output logic [CODE_W-1:0] ramp_code,
   output logic              ss_busy,
   output logic              ss_done,
   output logic [2:0]        ss_state
);

   localparam int BLK_W = $clog2(BLANK_CYC + 1);
   localparam logic [CODE_W-1:0] FULL     = '1;
   localparam logic [CODE_W-1:0] FULL_M1  = FULL - CODE_W'(1);
   localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLANK_CYC - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      BLANK     = 3'd1,
      RAMP      = 3'd2,
      DONE      = 3'd3,
      DISCHARGE = 3'd4
   } state_t;

   state_t            state;
   logic [BLK_W-1:0]  blank_cnt;
   logic [DIV_W-1:0]  presc;
   logic [DIV_W-1:0]  div_q;

   // Power pins carry no logic; gathered here so they are visibly consumed.
   logic unused_pins;
   assign unused_pins = CELV ^ CELG ^ SUB;

   logic abort;
   assign abort = fault | ~en;

   assign ss_state = state;

   // ss_busy / ss_done are registered alongside the state so they never see a
   // combinational path from en or fault.
   always_ff @(posedge CELCLK or negedge CELRSTN) begin
      if (!CELRSTN) begin
         state     <= IDLE;
         ramp_code <= '0;
         ss_busy   <= 1'b0;
         ss_done   <= 1'b0;
         blank_cnt <= '0;
         presc     <= '0;
         div_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               ramp_code <= '0;
               if (en && !fault) begin
                  state     <= BLANK;
                  blank_cnt <= '0;
                  ss_busy   <= 1'b1;
                  ss_done   <= 1'b0;
               end
            end

            BLANK, RAMP, DONE: begin
               if (abort) begin
                  // A zero code has nothing to discharge; skip straight to IDLE.
                  state     <= (ramp_code == '0) ? IDLE : DISCHARGE;
                  ss_busy   <= (ramp_code != '0);
                  ss_done   <= 1'b0;
                  blank_cnt <= '0;
                  presc     <= '0;
               end else if (state == BLANK) begin
                  if (blank_cnt == BLK_LAST) begin
                     // div is captured once here; later changes wait for the next ramp.
                     div_q     <= div;
                     presc     <= '0;
                     blank_cnt <= '0;
                     state     <= RAMP;
                  end else begin
                     blank_cnt <= blank_cnt + 1'b1;
                  end
               end else if (state == RAMP) begin
                  if (presc == div_q) begin
                     presc <= '0;
                     if (ramp_code >= FULL_M1) begin
                        // Step that reaches full scale also completes the ramp.
                        ramp_code <= FULL;
                        state     <= DONE;
                        ss_busy   <= 1'b0;
                        ss_done   <= 1'b1;
                     end else begin
                        ramp_code <= ramp_code + 1'b1;
                     end
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end else begin
                  ramp_code <= FULL;
               end
            end

            DISCHARGE: begin
               // en and fault are deliberately ignored until the code is back at 0.
               if (ramp_code <= CODE_W'(1)) begin
                  ramp_code <= '0;
                  state     <= IDLE;
                  ss_busy   <= 1'b0;
                  ss_done   <= 1'b0;
               end else begin
                  ramp_code <= ramp_code - 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               ramp_code <= '0;
               ss_busy   <= 1'b0;
               ss_done   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stepdown_softstart_seq.sv
// tb_stepdown_softstart_seq: directed bench for the soft-start sequencer.
// Stimulus pushes timestamped expected outputs; monitors compare them on the
// falling clock edge (or just after an asynchronous reset assertion).
module tb_stepdown_softstart_seq;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_BLANK = 3'd1;
   localparam logic [2:0] S_RAMP  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_DIS   = 3'd4;

   logic        CELCLK = 1'b0;
   logic        CELRSTN;
   logic        CELV, CELG, SUB;
   logic        en, fault;
   logic [11:0] div;
   logic [7:0]  ramp_code;
   logic        ss_busy, ss_done;
   logic [2:0]  ss_state;

   stepdown_softstart_seq dut (
      .CELCLK    (CELCLK),
      .CELRSTN   (CELRSTN),
      .CELV      (CELV),
      .CELG      (CELG),
      .SUB       (SUB),
      .en        (en),
      .fault     (fault),
      .div       (div),
      .ramp_code (ramp_code),
      .ss_busy   (ss_busy),
      .ss_done   (ss_done),
      .ss_state  (ss_state)
   );

   always #5 CELCLK = ~CELCLK;

   int cyc = 0;
   always @(posedge CELCLK) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      bit         is_async;
      logic [2:0] st;
      logic [7:0] code;
      logic       busy;
      logic       done;
      string      name;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   task automatic expect_at(input int c, input string nm, input logic [2:0] st,
                            input logic [7:0] code, input logic b, input logic d);
      exp_t e;
      e.cyc = c; e.is_async = 1'b0; e.st = st; e.code = code;
      e.busy = b; e.done = d; e.name = nm;
      q.push_back(e);
   endtask

   task automatic expect_async(input string nm);
      exp_t e;
      e.cyc = cyc; e.is_async = 1'b1; e.st = S_IDLE; e.code = 8'd0;
      e.busy = 1'b0; e.done = 1'b0; e.name = nm;
      q.push_back(e);
   endtask

   task automatic compare(input exp_t e);
      checks++;
      if (ss_state !== e.st || ramp_code !== e.code || ss_busy !== e.busy || ss_done !== e.done) begin
         errors++;
         $display("FAIL %s cyc=%0d got state=%0d code=%0d busy=%0b done=%0b expected state=%0d code=%0d busy=%0b done=%0b",
                  e.name, cyc, ss_state, ramp_code, ss_busy, ss_done, e.st, e.code, e.busy, e.done);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge CELCLK);
   endtask

   // Clocked monitor: consumes every expectation whose cycle has arrived.
   initial begin
      exp_t e;
      forever begin
         @(negedge CELCLK);
         while (q.size() > 0 && !q[0].is_async && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
               checks++;
               errors++;
               $display("FAIL %s missed: due cyc=%0d seen at cyc=%0d", e.name, e.cyc, cyc);
            end else begin
               compare(e);
            end
         end
      end
   end

   // Reset monitor: checks outputs shortly after reset falls, with no clock edge.
   initial begin
      forever begin
         @(negedge CELRSTN);
         #1;
         if (q.size() > 0 && q[0].is_async) compare(q.pop_front());
      end
   end

   initial begin
      #200000;
      checks++;
      errors++;
      $display("FAIL timeout cyc=%0d pending=%0d expected pending=0", cyc, q.size());
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int c, a, e2, d, s, r;
      CELRSTN = 1'b0; en = 1'b0; fault = 1'b0; div = 12'd0;
      CELV = 1'b1; CELG = 1'b0; SUB = 1'b0;

      // Reset state, then idle with en low.
      wait_until(2);
      c = cyc;
      expect_at(c + 1, "reset_idle", S_IDLE, 8'd0, 1'b0, 1'b0);
      expect_at(c + 3, "idle_no_en", S_IDLE, 8'd0, 1'b0, 1'b0);
      wait_until(c + 2);
      CELRSTN = 1'b1;
      wait_until(c + 4);

      // Full ramp with div=3: RAMP at +17, first step 4 cycles later, 255 after 1020.
      c = cyc; div = 12'd3; en = 1'b1;
      expect_at(c + 1,         "blank_entry",     S_BLANK, 8'd0,   1'b1, 1'b0);
      expect_at(c + 16,        "blank_last",      S_BLANK, 8'd0,   1'b1, 1'b0);
      expect_at(c + 17,        "ramp_entry",      S_RAMP,  8'd0,   1'b1, 1'b0);
      expect_at(c + 20,        "ramp_pre_step",   S_RAMP,  8'd0,   1'b1, 1'b0);
      expect_at(c + 21,        "ramp_first_step", S_RAMP,  8'd1,   1'b1, 1'b0);
      expect_at(c + 17 + 1019, "ramp_254",        S_RAMP,  8'd254, 1'b1, 1'b0);
      expect_at(c + 17 + 1020, "done_full",       S_DONE,  8'd255, 1'b0, 1'b1);
      expect_at(c + 17 + 1030, "done_hold",       S_DONE,  8'd255, 1'b0, 1'b1);
      wait_until(c + 17 + 1030);

      // fault + en=0 in DONE; en re-raised and a fault blip during DISCHARGE are ignored.
      a = cyc; fault = 1'b1; en = 1'b0;
      e2 = a + 273;
      expect_at(a + 1,    "dis_entry",      S_DIS,   8'd255, 1'b1, 1'b0);
      expect_at(a + 2,    "dis_first_dec",  S_DIS,   8'd254, 1'b1, 1'b0);
      expect_at(a + 12,   "dis_ignore_in",  S_DIS,   8'd244, 1'b1, 1'b0);
      expect_at(a + 255,  "dis_code1",      S_DIS,   8'd1,   1'b1, 1'b0);
      expect_at(a + 256,  "dis_to_idle",    S_IDLE,  8'd0,   1'b0, 1'b0);
      expect_at(a + 257,  "restart_blank",  S_BLANK, 8'd0,   1'b1, 1'b0);
      // Next ramp latches div=0; the later change to 7 must not slow it.
      expect_at(e2,       "fast_ramp_entry", S_RAMP, 8'd0,   1'b1, 1'b0);
      expect_at(e2 + 1,   "fast_step1",     S_RAMP,  8'd1,   1'b1, 1'b0);
      expect_at(e2 + 10,  "fast_step10",    S_RAMP,  8'd10,  1'b1, 1'b0);
      expect_at(e2 + 100, "fast_step100",   S_RAMP,  8'd100, 1'b1, 1'b0);
      expect_at(e2 + 254, "fast_step254",   S_RAMP,  8'd254, 1'b1, 1'b0);
      expect_at(e2 + 255, "fast_done",      S_DONE,  8'd255, 1'b0, 1'b1);
      wait_until(a + 1);
      fault = 1'b0; en = 1'b1; div = 12'd0;
      wait_until(a + 10);
      fault = 1'b1;
      wait_until(a + 11);
      fault = 1'b0;
      wait_until(a + 280);
      div = 12'd7;
      wait_until(e2 + 260);

      // en=0 alone in DONE takes the same discharge path.
      d = cyc; en = 1'b0;
      expect_at(d + 1,   "en_abort_dis",  S_DIS,  8'd255, 1'b1, 1'b0);
      expect_at(d + 256, "en_abort_idle", S_IDLE, 8'd0,   1'b0, 1'b0);
      expect_at(d + 258, "idle_en_low",   S_IDLE, 8'd0,   1'b0, 1'b0);
      wait_until(d + 258);

      // One-cycle fault pulse at code 100 (div=3), then automatic restart.
      s = cyc; en = 1'b1; div = 12'd3;
      r = s + 17;
      expect_at(s + 1,   "blank3",         S_BLANK, 8'd0,   1'b1, 1'b0);
      expect_at(r + 400, "code100",        S_RAMP,  8'd100, 1'b1, 1'b0);
      expect_at(r + 401, "code100_hold",   S_RAMP,  8'd100, 1'b1, 1'b0);
      expect_at(r + 402, "fault_dis",      S_DIS,   8'd100, 1'b1, 1'b0);
      expect_at(r + 403, "fault_dec",      S_DIS,   8'd99,  1'b1, 1'b0);
      expect_at(r + 501, "fault_code1",    S_DIS,   8'd1,   1'b1, 1'b0);
      expect_at(r + 502, "fault_idle",     S_IDLE,  8'd0,   1'b0, 1'b0);
      expect_at(r + 503, "fault_restart",  S_BLANK, 8'd0,   1'b1, 1'b0);
      wait_until(r + 401);
      fault = 1'b1;
      wait_until(r + 402);
      fault = 1'b0;

      // en dropped in BLANK with code 0: straight to IDLE, no DISCHARGE.
      wait_until(r + 505);
      en = 1'b0;
      expect_at(r + 506, "blank_abort_idle", S_IDLE, 8'd0, 1'b0, 1'b0);
      expect_at(r + 507, "blank_abort_stay", S_IDLE, 8'd0, 1'b0, 1'b0);

      // Asynchronous reset mid-ramp at code 57 (div=0).
      wait_until(r + 510);
      en = 1'b1; div = 12'd0;
      expect_at(r + 511, "blank4",     S_BLANK, 8'd0,  1'b1, 1'b0);
      expect_at(r + 527, "ramp4",      S_RAMP,  8'd0,  1'b1, 1'b0);
      expect_at(r + 584, "code57",     S_RAMP,  8'd57, 1'b1, 1'b0);
      wait_until(r + 584);
      #2;
      expect_async("async_reset");
      CELRSTN = 1'b0;
      expect_at(r + 585, "reset_held",        S_IDLE,  8'd0, 1'b0, 1'b0);
      expect_at(r + 587, "post_reset_blank",  S_BLANK, 8'd0, 1'b1, 1'b0);
      expect_at(r + 603, "post_reset_ramp",   S_RAMP,  8'd0, 1'b1, 1'b0);
      expect_at(r + 604, "post_reset_step",   S_RAMP,  8'd1, 1'b1, 1'b0);
      wait_until(r + 586);
      CELRSTN = 1'b1;
      wait_until(r + 610);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending=%0d expected pending=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stepdown_softstart_seq.md
# stepdown_softstart_seq

Soft-start sequencer for the step-down converter. It ramps the reference DAC code from zero to full scale at a programmable rate after enable. It discharges the code back to zero on fault or disable. Its `ss_busy` output drives the input of the 5V soft-start inverter, whose output is the active-high "soft-start complete / regulation allowed" flag consumed by the stepdown control loop.

## Interface
Parameters:
- CODE_W, 8, width of ramp DAC code; full scale = 2^CODE_W-1
- DIV_W, 12, width of ramp step-interval divider
- BLANK_CYC, 16, precharge/settle cycles between enable and first ramp step (≥1)

Ports:
- CELCLK  input  1  sequencer clock; all state changes on rising edge
- CELRSTN  input  1  reset; asynchronous and active-low
- CELV  input  1  5V supply pin; no functional behaviour
- CELG  input  1  ground pin; no functional behaviour
- SUB  input  1  substrate pin; no functional behaviour
- en  input  1  soft-start enable, synchronous to CELCLK
- fault  input  1  converter fault (OCP/UVLO), synchronous, level
- div  input  DIV_W  cycles-per-step minus one; sampled on BLANK→RAMP
- ramp_code  output  CODE_W  reference DAC code
- ss_busy  output  1  high in BLANK, RAMP and DISCHARGE; feeds the inverter input
- ss_done  output  1  high only in DONE
- ss_state  output  3  IDLE=0, BLANK=1, RAMP=2, DONE=3, DISCHARGE=4

## Operation
- Reset (CELRSTN low, asynchronous): state IDLE, ramp_code=0, ss_busy=0, ss_done=0, all counters 0, div latch 0. Release is synchronous to the next CELCLK edge.
- IDLE: ramp_code=0. If en=1 and fault=0, go to BLANK. Otherwise stay.
- BLANK: blank counter counts BLANK_CYC cycles. On the last cycle, latch div into div_q, clear the prescaler, and go to RAMP.
- RAMP: the prescaler counts 0..div_q. In the cycle where prescaler==div_q, ramp_code increments by 1 and the prescaler clears. When the increment produces full scale, go to DONE on the same edge. div_q=0 means one step per cycle. Later changes on div are ignored until the next BLANK exit.
- DONE: ramp_code holds full scale and ss_done=1. The state stays until abort.
- Abort: fault=1, or en=0, in BLANK, RAMP or DONE.
  - If ramp_code=0, go directly to IDLE.
  - Otherwise go to DISCHARGE.
  - fault takes priority; both causes take the same path.
- DISCHARGE: ramp_code decrements by 1 every cycle regardless of div_q. The edge that writes 0 also moves the state to IDLE. en and fault are ignored during DISCHARGE.
- Restart: in IDLE, requires en=1 and fault=0, so there is a minimum of one IDLE cycle between DISCHARGE and BLANK.
- Arithmetic: ramp_code never wraps. It saturates at full scale in RAMP/DONE and at 0 in DISCHARGE. The prescaler is DIV_W bits and the blank counter is clog2(BLANK_CYC+1) bits.
- Output decode: ss_busy and ss_done are decoded from registered state, with no combinational path from en or fault. ss_busy and ss_done are never both 1.

## Timing
- en high sampled at edge t in IDLE: ss_state=BLANK and ss_busy=1 after edge t.
- Last BLANK cycle at edge t+BLANK_CYC: RAMP follows that edge.
- First step: ramp_code=1 after (div_q+1) cycles in RAMP.
- Full scale: reached (2^CODE_W-1)·(div_q+1) cycles after RAMP entry. ss_done rises and ss_busy falls on the same edge as full scale.
- Abort latency: one edge from fault or en sampled to the DISCHARGE/IDLE state. The decrement starts on the following edge.
- Discharge from code N: N cycles. IDLE and ss_busy=0 occur on the edge that writes 0.
- Asynchronous reset mid-ramp or mid-discharge: ramp_code goes to 0 immediately with no clock required.

## Test plan
- Reset, then en=1, div=3, BLANK_CYC=16 -> BLANK for 16 cycles; ramp_code=1 four cycles after RAMP entry; ramp_code=255 and ss_done=1 at 1020 cycles after RAMP entry; ss_busy=0 from that edge.
- div=0, then div changed to 7 mid-ramp -> one step per cycle throughout; 255 reached 255 cycles after RAMP entry.
- fault pulse of one cycle at ramp_code=100 with div=3 -> DISCHARGE on the next edge; code goes 100→0 in 100 cycles; IDLE with en still 1 then restarts BLANK one cycle later.
- en dropped during BLANK (code=0) -> IDLE on the next edge; ramp_code stays 0; no DISCHARGE visit.
- fault and en=0 asserted in DONE (code 255), en re-raised during DISCHARGE -> discharge completes in 255 cycles, ignoring en; BLANK only after IDLE sees en=1 and fault=0.
- CELRSTN asserted asynchronously mid-RAMP at code 57 -> ramp_code=0, ss_busy=0, ss_done=0, ss_state=IDLE without a clock edge; the first post-release edge with en=1 enters BLANK.
